// File: rtl/sc_isa_pkg.sv
// ISA constants, mnemonic codes and encoder FSM states shared by
// the instruction packer and the program-load control unit.
package sc_isa_pkg;

    typedef enum logic [4:0] {
        M_ADD  = 5'd0,
        M_SUB  = 5'd1,
        M_AND  = 5'd2,
        M_OR   = 5'd3,
        M_XOR  = 5'd4,
        M_GT   = 5'd5,
        M_SLL  = 5'd6,
        M_SRL  = 5'd7,
        M_SRA  = 5'd8,
        M_JR   = 5'd9,
        M_ADDI = 5'd10,
        M_ANDI = 5'd11,
        M_ORI  = 5'd12,
        M_XORI = 5'd13,
        M_LW   = 5'd14,
        M_SW   = 5'd15,
        M_BEQ  = 5'd16,
        M_BNE  = 5'd17,
        M_LUI  = 5'd18,
        M_J    = 5'd19,
        M_JAL  = 5'd20
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_GT  = 6'b100111;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [31:0] r_word(
        input logic [5:0] funct,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sa
    );
        return {OP_RTYPE, rs, rt, rd, sa, funct};
    endfunction

    function automatic logic [31:0] i_word(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/sc_inst_pack.sv
// Combinational packer: mnemonic code plus operand fields to a
// 32-bit instruction word, with a flag for codes outside the ISA.
module sc_inst_pack
    import sc_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (mnem)
            M_ADD:  word = r_word(F_ADD, rs, rt, rd, 5'd0);
            M_SUB:  word = r_word(F_SUB, rs, rt, rd, 5'd0);
            M_AND:  word = r_word(F_AND, rs, rt, rd, 5'd0);
            M_OR:   word = r_word(F_OR,  rs, rt, rd, 5'd0);
            M_XOR:  word = r_word(F_XOR, rs, rt, rd, 5'd0);
            M_GT:   word = r_word(F_GT,  rs, rt, rd, 5'd0);
            M_SLL:  word = r_word(F_SLL, 5'd0, rt, rd, sa);
            M_SRL:  word = r_word(F_SRL, 5'd0, rt, rd, sa);
            M_SRA:  word = r_word(F_SRA, 5'd0, rt, rd, sa);
            M_JR:   word = r_word(F_JR,  rs, 5'd0, 5'd0, 5'd0);
            M_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            M_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
            M_ORI:  word = i_word(OP_ORI,  rs, rt, imm);
            M_XORI: word = i_word(OP_XORI, rs, rt, imm);
            M_LW:   word = i_word(OP_LW,   rs, rt, imm);
            M_SW:   word = i_word(OP_SW,   rs, rt, imm);
            M_BEQ:  word = i_word(OP_BEQ,  rs, rt, imm);
            M_BNE:  word = i_word(OP_BNE,  rs, rt, imm);
            M_LUI:  word = i_word(OP_LUI,  5'd0, rt, imm);
            M_J:    word = {OP_J, target};
            M_JAL:  word = {OP_JAL, target};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sc_inst_enc.sv
// Program-load encoder: accepts mnemonic records, emits encoded words
// with their byte addresses through a one-deep output register.
module sc_inst_enc
    import sc_isa_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_cnt
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ov_q, ov_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   oaddr_q, oaddr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [31:0] pk_word;
    logic        pk_legal;
    logic        xfer;

    sc_inst_pack u_pack (
        .mnem   (mnem),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .sa     (sa),
        .imm    (imm),
        .target (target),
        .word   (pk_word),
        .legal  (pk_legal)
    );

    assign in_ready = (state_q == ST_RUN) & (~ov_q | out_ready);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ov_d    = ov_q;
        inst_d  = inst_q;
        oaddr_d = oaddr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (ov_q & out_ready) ov_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (pk_legal) begin
                        ov_d    = 1'b1;
                        inst_d  = pk_word;
                        oaddr_d = {{(30-AW){1'b0}}, addr_q, 2'b00};
                        addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end
                    if (in_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish only once the last word has left the register
                if (~ov_q | out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ov_q    <= 1'b0;
            inst_q  <= '0;
            oaddr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ov_q    <= ov_d;
            inst_q  <= inst_d;
            oaddr_q <= oaddr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = ov_q;
    assign out_inst  = inst_q;
    assign out_addr  = oaddr_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_sc_inst_enc.sv
// Directed bench for sc_inst_enc: default-width and AW=2 instances
// share one stimulus stream.
module tb_sc_inst_enc;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [4:0]  mnem, rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_ready;

    logic        in_ready, out_valid, done, err;
    logic [31:0] out_inst, out_addr;
    logic [7:0]  err_cnt;

    logic        in_ready2, out_valid2, done2, err2;
    logic [31:0] out_inst2, out_addr2;
    logic [7:0]  err_cnt2;

    int checks = 0;
    int errors = 0;

    sc_inst_enc #(.AW(6)) u6 (
        .clock(clock), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .done(done), .err(err), .err_cnt(err_cnt)
    );

    sc_inst_enc #(.AW(2)) u2 (
        .clock(clock), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .imm(imm), .target(target),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_inst(out_inst2), .out_addr(out_addr2),
        .done(done2), .err(err2), .err_cnt(err_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] a_m, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic [4:0] a_rd,
                        input logic [4:0] a_sa, input logic [15:0] a_imm,
                        input logic [25:0] a_tg, input logic a_last);
        mnem = a_m; rs = a_rs; rt = a_rt; rd = a_rd; sa = a_sa;
        imm = a_imm; target = a_tg; in_last = a_last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; sa = '0;
        imm = '0; target = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_inready", {31'd0, in_ready}, 32'd0);
        resetn = 1'b1;
        tick();

        // single ADD, last
        pulse_start();
        chk("run_inready", {31'd0, in_ready}, 32'd1);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_inst", out_inst, 32'h0022_1820);
        chk("add_addr", out_addr, 32'h0);
        chk("drain_inready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("add_done", {31'd0, done}, 32'd1);
        chk("add_valid_off", {31'd0, out_valid}, 32'd0);
        tick();
        chk("add_done_off", {31'd0, done}, 32'd0);

        // LW then J
        pulse_start();
        send(5'd14, 5'd0, 5'd4, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
        chk("lw_inst", out_inst, 32'h8C04_0008);
        chk("lw_addr", out_addr, 32'h0);
        send(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
        chk("j_inst", out_inst, 32'h0800_0010);
        chk("j_addr", out_addr, 32'h4);
        chk("j_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("j_done", {31'd0, done}, 32'd1);
        tick();
        chk("j_done_off", {31'd0, done}, 32'd0);

        // SLL with backpressure
        pulse_start();
        out_ready = 1'b0;
        send(5'd6, 5'd7, 5'd2, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sll_inst", out_inst, 32'h0002_1100);
            chk("sll_valid", {31'd0, out_valid}, 32'd1);
            chk("sll_addr", out_addr, 32'h0);
            chk("stall_inready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_inready", {31'd0, in_ready}, 32'd1);
        send(5'd1, 5'd4, 5'd5, 5'd6, 5'd9, 16'd0, 26'd0, 1'b1);
        chk("sub_inst", out_inst, 32'h0085_3022);
        chk("sub_addr", out_addr, 32'h4);
        tick();
        chk("sll_done", {31'd0, done}, 32'd1);
        tick();

        // illegal code between two ADDs
        pulse_start();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("ill_add1_addr", out_addr, 32'h0);
        send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_errcnt", {24'd0, err_cnt}, 32'd1);
        chk("ill_novalid", {31'd0, out_valid}, 32'd0);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("ill_add2_inst", out_inst, 32'h0022_1820);
        chk("ill_add2_addr", out_addr, 32'h4);
        tick();
        chk("ill_done", {31'd0, done}, 32'd1);
        chk("ill_sticky", {31'd0, err}, 32'd1);
        tick();

        // illegal code with last still terminates
        pulse_start();
        chk("start_clr_err", {31'd0, err}, 32'd0);
        chk("start_clr_cnt", {24'd0, err_cnt}, 32'd0);
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("illast_inready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("illast_done", {31'd0, done}, 32'd1);
        chk("illast_cnt", {24'd0, err_cnt}, 32'd1);
        tick();

        // start ignored in RUN; also LUI and JR masking
        pulse_start();
        send(5'd18, 5'd9, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0, 1'b0);
        chk("lui_inst", out_inst, 32'h3C03_BEEF);
        pulse_start();
        send(5'd9, 5'd31, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 1'b1);
        chk("jr_inst", out_inst, 32'h03E0_0008);
        chk("start_ign_addr", out_addr, 32'h4);
        tick();
        tick();

        // err_cnt saturation
        pulse_start();
        for (int i = 0; i < 260; i++)
            send(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("sat_errcnt", {24'd0, err_cnt}, 32'd255);
        send(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        tick();
        tick();

        // address wrap on AW=2 and async reset mid-run
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(5'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'd0, 26'd0, 1'b0);
            chk("w6_addr", out_addr, 32'(i * 4));
            chk("w2_addr", out_addr2, 32'((i % 4) * 4));
        end
        chk("w2_inst", out_inst2, 32'h0022_2020);
        resetn = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_inst", out_inst, 32'd0);
        chk("ar_addr", out_addr, 32'd0);
        chk("ar_inready", {31'd0, in_ready}, 32'd0);
        tick();
        resetn = 1'b1;
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("ar_idle_noacc", {31'd0, out_valid}, 32'd0);
        pulse_start();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("ar_restart_inst", out_inst, 32'h0022_1820);
        chk("ar_restart_addr", out_addr, 32'h0);
        chk("ar_restart_addr2", out_addr2, 32'h0);
        tick();
        chk("ar_restart_done", {31'd0, done}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_inst_enc.md
SC_INST_ENC -- requirements
Module: sc_inst_enc

Interface
REQ-001 SHALL have parameter AW, default 6, giving the instruction-memory word-address width (depth 2^AW words).
REQ-002 SHALL have ports: clock  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, begin program load; in_valid  in  1; in_ready  out  1; in_last  in  1  marks final instruction.
REQ-004 SHALL have ports: mnem  in  5  instruction code; rs, rt, rd, sa  in  5 each; imm  in  16; target  in  26.
REQ-005 SHALL have ports: out_valid  out  1; out_ready  in  1; out_inst  out  32  encoded word; out_addr  out  32  byte address (word address << 2).
REQ-006 SHALL have ports: done  out  1  one-cycle pulse; err  out  1  sticky illegal-code flag; err_cnt  out  8  saturating count of dropped codes.

Function
REQ-007 SHALL implement states IDLE, RUN, DRAIN; reset state is IDLE.
REQ-008 IDLE: in_ready=0; on start, SHALL clear the word-address counter, err and err_cnt, and go to RUN.
REQ-009 RUN: in_ready = ~out_valid | out_ready; a transfer occurs when in_valid & in_ready.
REQ-010 Accepted legal code SHALL appear on out_inst/out_addr with out_valid=1 on the next cycle (latency 1); the word address then increments by 1, wrapping from 2^AW-1 to 0.
REQ-011 out_inst/out_addr/out_valid SHALL hold stable while out_valid & ~out_ready.
REQ-012 Codes 0-20 map to ADD,SUB,AND,OR,XOR,GT,SLL,SRL,SRA,JR,ADDI,ANDI,ORI,XORI,LW,SW,BEQ,BNE,LUI,J,JAL.
REQ-013 R-type (op 000000): funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, GT 100111, SLL 000000, SRL 000010, SRA 000011, JR 001000.
REQ-014 Shifts SHALL force rs field to 0; JR SHALL force rt, rd and sa to 0; other R-type SHALL force sa to 0.
REQ-015 I-type opcodes: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, LUI 001111; fields are op|rs|rt|imm; LUI SHALL force rs to 0.
REQ-016 J 000010, JAL 000011: fields are op|target.
REQ-017 Codes 21-31 SHALL be accepted and dropped: no output, no address increment, err set, err_cnt incremented (saturating at 255).
REQ-018 Accepted transfer with in_last=1 SHALL move to DRAIN (in_ready=0); DRAIN waits until out_valid=0 or its output is consumed, then pulses done for one cycle and returns to IDLE.
REQ-019 An illegal code with in_last=1 SHALL still terminate the load (DRAIN then done).
REQ-020 start outside IDLE SHALL be ignored.

Reset
REQ-021 resetn low SHALL asynchronously force IDLE, out_valid=0, out_inst=0, out_addr=0, done=0, err=0, err_cnt=0, address counter=0; an in-flight word is discarded.

Structure
REQ-022 Opcode/funct constants, mnemonic code enumeration and state encoding SHALL live in shared package sc_isa_pkg, also used by the control unit.
REQ-023 Combinational packing SHALL be sub-module sc_inst_pack (mnem+fields -> 32-bit word + legal flag); sc_inst_enc owns FSM, counter and output register.

Verification
REQ-024 start; ADD rs=1 rt=2 rd=3 -> out_inst 0x00221820, out_addr 0x0.
REQ-025 LW rs=0 rt=4 imm=8 then J target=0x10 (in_last) -> 0x8C040008 @0x0, 0x08000010 @0x4, done pulse one cycle after last output consumed.
REQ-026 SLL rt=2 rd=2 sa=4 rs=7 -> 0x00021100 (rs masked); out_ready held low 3 cycles -> output stable, in_ready=0.
REQ-027 code 25 between two ADDs -> err=1, err_cnt=1, ADDs at 0x0 and 0x4 with no gap.
REQ-028 AW=2, five legal words -> fifth at out_addr 0x0 (wrap); resetn low mid-RUN -> all outputs 0, IDLE, start required again.
